uc_es_ctrl: RTL and testbench
=============================

Name: uc_es_ctrl

Overview:
Control unit for the single-cycle CPU with I/O. It decodes the 6-bit opcode from the datapath and drives the datapath control lines: s_inc, s_inm, we3, wez, op_alu, plus a new PC enable and an input-data select. It sequences IN/OUT instructions with valid/ready handshakes to external ports, stalling the PC until each transfer completes or times out. It also implements a HALT state.

Parameters:
TO_W, 8, width of the I/O timeout counter
TIMEOUT, 200, number of stall cycles before an I/O transfer is aborted (1..2^TO_W-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low
opcode  in  6  instruction[15:10] from the datapath
s_z  in  1  registered zero flag from the datapath
in_valid  in  1  external input port has data
out_ready  in  1  external output port accepts data
s_inc  out  1  1 = PC+1, 0 = load jump target
s_inm  out  1  1 = write immediate to wd3
s_in  out  1  1 = write input-port data to wd3 (overrides s_inm path)
we3  out  1  register-file write enable
wez  out  1  zero-flag write enable
op_alu  out  3  ALU operation
pc_en  out  1  PC load enable (0 = stall)
in_ack  out  1  one-cycle pulse: input word consumed
out_valid  out  1  output port data valid
io_err  out  1  sticky flag: an I/O transfer timed out
halted  out  1  CPU stopped

Behaviour:
- Opcode decode:
  - 1oooxx: ALU. op_alu = opcode[4:2], we3 = 1, wez = 1.
  - 0000xx: LI. s_inm = 1, we3 = 1.
  - 000100: J. s_inc = 0.
  - 000101: JZ. s_inc = ~s_z.
  - 000110: JNZ. s_inc = s_z.
  - 001000: IN.
  - 001001: OUT.
  - 001111: HALT.
  - All other opcodes: NOP (PC+1, no writes).
- Defaults when an opcode does not set a line: s_inc = 1, s_inm = 0, s_in = 0, we3 = 0, wez = 0, op_alu = 000, in_ack = 0, out_valid = 0.
- Registered state: state ∈ {RUN, WAIT_IN, WAIT_OUT, HALT}, cnt[TO_W-1:0], io_err.
- All other outputs are combinational (Mealy) from state, opcode, s_z, in_valid and out_ready.
- While reset = 0:
  - state = RUN, cnt = 0, io_err = 0.
  - pc_en, we3, wez, in_ack, out_valid all forced to 0; halted = 0.
- RUN state:
  - Non-I/O opcodes: pc_en = 1, single cycle.
  - IN with in_valid = 1: s_in = 1, we3 = 1, in_ack = 1, pc_en = 1. Completes in the same cycle; stay in RUN.
  - IN with in_valid = 0: pc_en = 0, we3 = 0. Next state WAIT_IN, cnt = 1.
  - OUT: out_valid = 1. If out_ready = 1: pc_en = 1, stay in RUN. Otherwise pc_en = 0, next state WAIT_OUT, cnt = 1.
  - HALT: pc_en = 0, next state HALT.
- WAIT_IN state (opcode is stable because the PC is stalled):
  - pc_en = 0 until in_valid = 1.
  - When in_valid = 1: the same outputs as a zero-wait IN, then next state RUN, cnt = 0.
  - Otherwise cnt increments.
  - Timeout: when cnt == TIMEOUT and in_valid = 0, abort. pc_en = 1 (instruction skipped, no register write), io_err <= 1, next state RUN.
- WAIT_OUT state: out_valid = 1 held continuously. Completion on out_ready = 1, with timeout handled as in WAIT_IN.
- Simultaneous events: valid/ready in the timeout cycle → the transfer wins and io_err is unchanged.
- HALT state: halted = 1, pc_en = 0, all write enables 0. Exit only via reset.
- io_err is cleared only by reset.
- Reset asserted mid-wait: immediate return to RUN with no ack pulse and out_valid dropped asynchronously.

Test Plan:
- ALU/LI/jumps:
  - opcode 101100 → op_alu = 011, we3 = 1, wez = 1, pc_en = 1, s_inc = 1.
  - opcode 000000 → s_inm = 1, we3 = 1, wez = 0.
  - JZ with s_z = 1 → s_inc = 0; with s_z = 0 → s_inc = 1.
  - JNZ → the inverse of JZ.
- Zero-wait IN: opcode 001000 with in_valid = 1 → single cycle with s_in = 1, we3 = 1, in_ack = 1, pc_en = 1. State stays RUN.
- Stalled IN: in_valid = 0 for 5 cycles, then 1 → pc_en = 0 and we3 = 0 for 5 cycles. The 6th cycle has we3 = 1, in_ack = 1, pc_en = 1. io_err = 0.
- OUT timeout (TIMEOUT = 4): out_ready held 0 → out_valid = 1 held. On the 5th cycle pc_en = 1 with no writes; io_err = 1 from the next cycle.
  - Repeat with out_ready = 1 exactly in that 5th cycle → normal completion, io_err stays 0.
- HALT: opcode 001111 → halted = 1 and pc_en = 0 for 20+ cycles regardless of inputs. Asserting reset = 0 returns to RUN with halted = 0.
- Asynchronous reset mid-WAIT_IN (no clock edge) → out_valid, in_ack and pc_en go 0 immediately. After release: state RUN, cnt = 0, io_err = 0.

Source files
------------

// File: rtl/uc_es_ctrl.sv
// Control unit for the single-cycle CPU with I/O: opcode decode plus IN/OUT
// handshake sequencing with PC stall, transfer timeout and a HALT state.
module uc_es_ctrl #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       s_z,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       s_inc,
    output logic       s_inm,
    output logic       s_in,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op_alu,
    output logic       pc_en,
    output logic       in_ack,
    output logic       out_valid,
    output logic       io_err,
    output logic       halted
);
    typedef enum logic [1:0] {RUN, WAIT_IN, WAIT_OUT, HALT} state_t;

    state_t            state, state_nxt;
    logic [TO_W-1:0]   cnt, cnt_nxt;
    logic              err_set;
    logic              we3_d, wez_d, pc_en_d, in_ack_d, out_valid_d, halted_d;

    logic is_in, is_out, is_halt, expired;
    assign is_in   = (opcode == 6'b001000);
    assign is_out  = (opcode == 6'b001001);
    assign is_halt = (opcode == 6'b001111);
    assign expired = (cnt == TO_W'(TIMEOUT));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        err_set     = 1'b0;
        s_inc       = 1'b1;
        s_inm       = 1'b0;
        s_in        = 1'b0;
        we3_d       = 1'b0;
        wez_d       = 1'b0;
        op_alu      = 3'b000;
        pc_en_d     = 1'b0;
        in_ack_d    = 1'b0;
        out_valid_d = 1'b0;
        halted_d    = 1'b0;
        case (state)
            RUN: begin
                if (is_in) begin
                    if (in_valid) begin
                        s_in     = 1'b1;
                        we3_d    = 1'b1;
                        in_ack_d = 1'b1;
                        pc_en_d  = 1'b1;
                    end else begin
                        state_nxt = WAIT_IN;
                        cnt_nxt   = TO_W'(1);
                    end
                end else if (is_out) begin
                    out_valid_d = 1'b1;
                    if (out_ready) begin
                        pc_en_d = 1'b1;
                    end else begin
                        state_nxt = WAIT_OUT;
                        cnt_nxt   = TO_W'(1);
                    end
                end else if (is_halt) begin
                    state_nxt = HALT;
                end else begin
                    pc_en_d = 1'b1;
                    if (opcode[5]) begin
                        op_alu = opcode[4:2];
                        we3_d  = 1'b1;
                        wez_d  = 1'b1;
                    end else if (opcode[5:2] == 4'b0000) begin
                        s_inm = 1'b1;
                        we3_d = 1'b1;
                    end else if (opcode == 6'b000100) begin
                        s_inc = 1'b0;
                    end else if (opcode == 6'b000101) begin
                        s_inc = ~s_z;
                    end else if (opcode == 6'b000110) begin
                        s_inc = s_z;
                    end
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    s_in      = 1'b1;
                    we3_d     = 1'b1;
                    in_ack_d  = 1'b1;
                    pc_en_d   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (expired) begin
                    // Abort: skip the instruction without writing anything
                    pc_en_d   = 1'b1;
                    err_set   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end
            WAIT_OUT: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    pc_en_d   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (expired) begin
                    pc_en_d   = 1'b1;
                    err_set   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end
            default: halted_d = 1'b1;
        endcase
    end

    // Reset gates the side-effecting lines combinationally so they drop at once
    assign pc_en     = reset & pc_en_d;
    assign we3       = reset & we3_d;
    assign wez       = reset & wez_d;
    assign in_ack    = reset & in_ack_d;
    assign out_valid = reset & out_valid_d;
    assign halted    = reset & halted_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            cnt    <= '0;
            io_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (err_set) io_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uc_es_ctrl.sv
// Scoreboard bench for uc_es_ctrl: two instances (TIMEOUT=200 and TIMEOUT=4)
// share stimulus; each expectation carries a mask of instances it applies to.
module tb_uc_es_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b010000;
    logic       s_z = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

    logic       a_s_inc, a_s_inm, a_s_in, a_we3, a_wez, a_pc_en, a_in_ack, a_out_valid, a_io_err, a_halted;
    logic [2:0] a_op_alu;
    logic       b_s_inc, b_s_inm, b_s_in, b_we3, b_wez, b_pc_en, b_in_ack, b_out_valid, b_io_err, b_halted;
    logic [2:0] b_op_alu;

    always #5 clk = ~clk;

    uc_es_ctrl d0 (
        .clk(clk), .reset(rst_n), .opcode(opcode), .s_z(s_z), .in_valid(in_valid), .out_ready(out_ready),
        .s_inc(a_s_inc), .s_inm(a_s_inm), .s_in(a_s_in), .we3(a_we3), .wez(a_wez), .op_alu(a_op_alu),
        .pc_en(a_pc_en), .in_ack(a_in_ack), .out_valid(a_out_valid), .io_err(a_io_err), .halted(a_halted)
    );

    uc_es_ctrl #(.TO_W(8), .TIMEOUT(4)) d4 (
        .clk(clk), .reset(rst_n), .opcode(opcode), .s_z(s_z), .in_valid(in_valid), .out_ready(out_ready),
        .s_inc(b_s_inc), .s_inm(b_s_inm), .s_in(b_s_in), .we3(b_we3), .wez(b_wez), .op_alu(b_op_alu),
        .pc_en(b_pc_en), .in_ack(b_in_ack), .out_valid(b_out_valid), .io_err(b_io_err), .halted(b_halted)
    );

    // {s_inc,s_inm,s_in,we3,wez,op_alu[2:0],pc_en,in_ack,out_valid,io_err,halted}
    wire [12:0] act0 = {a_s_inc, a_s_inm, a_s_in, a_we3, a_wez, a_op_alu, a_pc_en, a_in_ack, a_out_valid, a_io_err, a_halted};
    wire [12:0] act4 = {b_s_inc, b_s_inm, b_s_in, b_we3, b_wez, b_op_alu, b_pc_en, b_in_ack, b_out_valid, b_io_err, b_halted};

    typedef struct {
        logic [12:0] v;
        logic [1:0]  m;   // bit0: d0, bit1: d4
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    event samp_ev;

    localparam logic [5:0] NOP = 6'b010000, OP_IN = 6'b001000, OP_OUT = 6'b001001, OP_HALT = 6'b001111;

    function automatic logic [12:0] ex(logic inc, logic inm, logic sin, logic w3, logic wz, logic [2:0] alu,
                                       logic pe, logic ack, logic ov, logic err, logic hlt);
        return {inc, inm, sin, w3, wz, alu, pe, ack, ov, err, hlt};
    endfunction

    // Monitor: drains the queue at every negedge or on an explicit mid-cycle sample
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or samp_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.m[0]) begin
                    n_chk++;
                    if (act0 === e.v) n_pass++;
                    else $display("FAIL %s (T=200): got %b expected %b", e.nm, act0, e.v);
                end
                if (e.m[1]) begin
                    n_chk++;
                    if (act4 === e.v) n_pass++;
                    else $display("FAIL %s (T=4): got %b expected %b", e.nm, act4, e.v);
                end
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic z, input logic iv, input logic ordy,
                       input logic [12:0] v, input logic [1:0] m, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = op; s_z = z; in_valid = iv; out_ready = ordy;
        e.v = v; e.m = m; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0; opcode = NOP; in_valid = 1'b0; out_ready = 1'b0;
        e.v = ex(1,0,0,0,0,3'b000,0,0,0,0,0); e.m = 2'b11; e.nm = "reset";
        q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [12:0] E_STALL = 13'b1_0_0_0_0_000_0_0_0_0_0;
    localparam logic [12:0] E_OWAIT = 13'b1_0_0_0_0_000_0_0_1_0_0;
    localparam logic [12:0] E_NOP   = 13'b1_0_0_0_0_000_1_0_0_0_0;
    localparam logic [12:0] E_HALT  = 13'b1_0_0_0_0_000_0_0_0_0_1;

    initial begin
        exp_t e;
        logic [5:0] hop [4];
        hop[0] = 6'b101100; hop[1] = OP_IN; hop[2] = OP_OUT; hop[3] = 6'b000000;

        // Reset state held over a couple of cycles
        cyc(NOP, 0, 1, 1, ex(1,0,0,0,0,3'b000,0,0,0,0,0), 2'b11, "rst_hold");
        cyc(OP_IN, 0, 1, 1, ex(1,0,1,0,0,3'b000,0,0,0,0,0), 2'b11, "rst_in");
        @(posedge clk); #1; rst_n = 1'b1;

        // Decode
        cyc(6'b101100, 0, 0, 0, ex(1,0,0,1,1,3'b011,1,0,0,0,0), 2'b11, "alu");
        cyc(6'b000000, 0, 0, 0, ex(1,1,0,1,0,3'b000,1,0,0,0,0), 2'b11, "li");
        cyc(6'b000100, 0, 0, 0, ex(0,0,0,0,0,3'b000,1,0,0,0,0), 2'b11, "j");
        cyc(6'b000101, 1, 0, 0, ex(0,0,0,0,0,3'b000,1,0,0,0,0), 2'b11, "jz_z1");
        cyc(6'b000101, 0, 0, 0, ex(1,0,0,0,0,3'b000,1,0,0,0,0), 2'b11, "jz_z0");
        cyc(6'b000110, 1, 0, 0, ex(1,0,0,0,0,3'b000,1,0,0,0,0), 2'b11, "jnz_z1");
        cyc(6'b000110, 0, 0, 0, ex(0,0,0,0,0,3'b000,1,0,0,0,0), 2'b11, "jnz_z0");
        cyc(NOP, 0, 1, 1, E_NOP, 2'b11, "nop");

        // Zero-wait IN / OUT
        cyc(OP_IN, 0, 1, 0, ex(1,0,1,1,0,3'b000,1,1,0,0,0), 2'b11, "in_0wait");
        cyc(NOP, 0, 0, 0, E_NOP, 2'b11, "in_0wait_run");
        cyc(OP_OUT, 0, 0, 1, ex(1,0,0,0,0,3'b000,1,0,1,0,0), 2'b11, "out_0wait");
        cyc(NOP, 0, 0, 0, E_NOP, 2'b11, "out_0wait_run");

        // Stalled IN: 5 idle cycles then data (T=4 instance would time out at cycle 5)
        for (int i = 0; i < 4; i++) cyc(OP_IN, 0, 0, 0, E_STALL, 2'b11, "in_stall");
        cyc(OP_IN, 0, 0, 0, E_STALL, 2'b01, "in_stall5");
        cyc(OP_IN, 0, 1, 0, ex(1,0,1,1,0,3'b000,1,1,0,0,0), 2'b01, "in_done");
        cyc(NOP, 0, 0, 0, E_NOP, 2'b01, "in_done_run");
        do_reset();

        // OUT timeout on the T=4 instance
        for (int i = 0; i < 4; i++) cyc(OP_OUT, 0, 0, 0, E_OWAIT, 2'b11, "out_wait");
        cyc(OP_OUT, 0, 0, 0, ex(1,0,0,0,0,3'b000,1,0,1,0,0), 2'b10, "out_timeout");
        cyc(NOP, 0, 0, 0, ex(1,0,0,0,0,3'b000,1,0,0,1,0), 2'b10, "io_err_set");
        cyc(NOP, 0, 0, 0, ex(1,0,0,0,0,3'b000,1,0,0,1,0), 2'b10, "io_err_sticky");
        do_reset();

        // Ready arrives in the timeout cycle: transfer wins
        for (int i = 0; i < 4; i++) cyc(OP_OUT, 0, 0, 0, E_OWAIT, 2'b11, "out_wait2");
        cyc(OP_OUT, 0, 0, 1, ex(1,0,0,0,0,3'b000,1,0,1,0,0), 2'b11, "out_race");
        cyc(NOP, 0, 0, 0, E_NOP, 2'b11, "out_race_noerr");

        // HALT
        cyc(OP_HALT, 0, 0, 0, E_STALL, 2'b11, "halt_enter");
        for (int i = 0; i < 22; i++)
            cyc(hop[i % 4], i[0], i[1], i[2], E_HALT, 2'b11, "halted");
        do_reset();
        cyc(NOP, 0, 0, 0, E_NOP, 2'b11, "halt_exit");

        // Asynchronous reset in WAIT_IN, mid-cycle
        cyc(OP_IN, 0, 0, 0, E_STALL, 2'b11, "ain_enter");
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        e.v = ex(1,0,1,1,0,3'b000,1,1,0,0,0); e.m = 2'b11; e.nm = "ain_ack";
        q.push_back(e);
        #1 -> samp_ev;
        #1 rst_n = 1'b0;
        e.v = ex(1,0,1,0,0,3'b000,0,0,0,0,0); e.m = 2'b11; e.nm = "async_rst";
        q.push_back(e);
        #1 -> samp_ev;
        @(posedge clk);
        #1 rst_n = 1'b1;
        // After release: RUN with cnt cleared, so T=4 times out on exactly the 5th cycle
        for (int i = 0; i < 4; i++) cyc(OP_IN, 0, 0, 0, E_STALL, 2'b11, "post_rst_wait");
        cyc(OP_IN, 0, 0, 0, E_NOP, 2'b10, "post_rst_to");
        cyc(NOP, 0, 0, 0, ex(1,0,0,0,0,3'b000,1,0,0,1,0), 2'b10, "post_rst_err");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
